// File: rtl/ncr_seq.sv
// Sequential binomial-coefficient engine: C(n,r) via acc = acc*(n-k+i)/i, i = 1..k.
// One multiply cycle and W restoring-division cycles per factor; start/done handshake.
module ncr_seq #(
  parameter int unsigned N   = 4,
  parameter int unsigned OUT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   n_in,
  input  logic [N-1:0]   r_in,
  output logic           busy,
  output logic           done,
  output logic [OUT-1:0] result,
  output logic           err
);

  localparam int unsigned W    = OUT + N;
  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   n_q, n_d;
  logic [N-1:0]   k_q, k_d;
  logic [N-1:0]   i_q, i_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           pend_err_q, pend_err_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [OUT-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic [N-1:0]   n_minus_r;
  logic [N-1:0]   k_in;
  logic           r_gt_n;
  logic [N-1:0]   factor;
  logic [N:0]     trial;
  logic           fits;
  logic           div_last;

  assign r_gt_n    = r_in > n_in;
  assign n_minus_r = n_in - r_in;
  assign k_in      = (r_in < n_minus_r) ? r_in : n_minus_r;
  assign factor    = n_q - k_q + i_q;

  // Acc doubles as the dividend shift register; quotient bits enter at the LSB.
  assign trial     = {rem_q, acc_q[W-1]};
  assign fits      = trial >= {1'b0, i_q};
  assign div_last  = cnt_q == CntW'(W - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pend_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      i_q        <= i_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pend_err_q <= pend_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    i_d        = i_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    pend_err_d = pend_err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d        = n_in;
          k_d        = k_in;
          pend_err_d = r_gt_n;
          if (r_gt_n || (k_in == '0)) begin
            state_d = StFin;
          end else begin
            acc_d   = W'(1);
            i_d     = N'(1);
            state_d = StMul;
          end
        end
      end
      StMul: begin
        acc_d   = acc_q * W'(factor);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = StDiv;
      end
      StDiv: begin
        rem_d = fits ? (trial[N-1:0] - i_q) : trial[N-1:0];
        acc_d = {acc_q[W-2:0], fits};
        cnt_d = cnt_q + CntW'(1);
        if (div_last) begin
          if (i_q == k_q) begin
            state_d = StIdle;
          end else begin
            i_d     = i_q + N'(1);
            state_d = StMul;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy_d   = (state_d == StMul) || (state_d == StDiv);
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    if (state_q == StFin) begin
      done_d   = 1'b1;
      result_d = pend_err_q ? '0 : OUT'(1);
      err_d    = pend_err_q;
    end else if ((state_q == StDiv) && div_last && (i_q == k_q)) begin
      done_d   = 1'b1;
      result_d = acc_d[OUT-1:0];
      err_d    = 1'b0;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ncr_seq.sv
// Scoreboard bench for ncr_seq: driver pushes expected result/err/latency, monitor checks on done.
module tb_ncr_seq;

  localparam int unsigned N   = 4;
  localparam int unsigned OUT = 32;
  localparam int unsigned W   = OUT + N;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   n_in;
  logic [N-1:0]   r_in;
  logic           busy;
  logic           done;
  logic [OUT-1:0] result;
  logic           err;

  ncr_seq #(.N(N), .OUT(OUT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .n_in   (n_in),
    .r_in   (r_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  typedef struct {
    longint res;
    bit     e;
    longint lat;
    longint t0;
  } exp_t;

  exp_t   sb[$];
  longint cyc;
  int     tests;
  int     fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint fact(input int x);
    longint f = 1;
    for (int i = 2; i <= x; i++) f = f * i;
    return f;
  endfunction

  // Reference: closed-form binomial from factorials, latency from the step count.
  function automatic exp_t model(input int n, input int r);
    exp_t e;
    int   k;
    if (r > n) begin
      e.res = 0;
      e.e   = 1'b1;
      e.lat = 1;
    end else begin
      k     = (r < n - r) ? r : n - r;
      e.res = fact(n) / (fact(r) * fact(n - r));
      e.e   = 1'b0;
      e.lat = (k == 0) ? 1 : longint'(k) * (W + 1);
    end
    e.t0 = 0;
    return e;
  endfunction

  task automatic issue(input int n, input int r);
    exp_t e;
    start = 1'b1;
    n_in  = N'(n);
    r_in  = N'(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = model(n, r);
    e.t0  = cyc;
    sb.push_back(e);
    n_in  = N'($urandom);
    r_in  = N'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", done, 1);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t   e;
    longint el;
    bit     exp_busy;
    if (rst_n) begin
      exp_busy = 1'b0;
      if (sb.size() > 0) begin
        el       = cyc - sb[0].t0;
        exp_busy = (sb[0].lat > 1) && (el < sb[0].lat);
      end
      check("busy", busy, exp_busy);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("err", err, e.e);
          check("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    n_in  = '0;
    r_in  = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #2;
      check("idle_done", done, 0);
      check("idle_result", result, 0);
      check("idle_err", err, 0);
    end

    issue(4, 2);   wait_done(300);
    issue(15, 8);  wait_done(300);
    issue(15, 7);  wait_done(300);
    issue(6, 6);   wait_done(300);
    issue(5, 0);   wait_done(300);
    issue(3, 5);   wait_done(300);

    // A start pulse during MUL/DIV must be ignored.
    issue(4, 2);
    repeat (19) @(posedge clk);
    #2;
    start = 1'b1;
    n_in  = 4'd15;
    r_in  = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(300);
    issue(6, 1);   wait_done(300);

    // Reset mid-computation aborts without done.
    issue(15, 7);
    repeat (99) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", err, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_result", result, 0);
    issue(10, 3);  wait_done(300);

    for (int t = 0; t < 40; t++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      wait_done(300);
    end

    repeat (5) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
